// File: rtl/idu_fetch_queue.sv
// Fetch-to-decode instruction queue: 1-cycle enqueue-to-output latency, no bypass.
// Stall is absorbed by occupancy; in_ready drops when a full fetch bundle would not fit.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module idu_fetch_queue #(
  parameter int FETCH_WIDTH     = 2,
  parameter int DECODE_WIDTH    = 2,
  parameter int DEPTH           = 8,
  parameter int INST_ADDR_WIDTH = `INST_ADDR_WIDTH,
  localparam int CW = $clog2(FETCH_WIDTH + 1),
  localparam int DW = $clog2(DECODE_WIDTH + 1),
  localparam int OW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          flush,
  input  logic                                          in_valid,
  input  logic [CW-1:0]                                 in_count,
  input  logic [FETCH_WIDTH-1:0][31:0]                  in_instr,
  input  logic [INST_ADDR_WIDTH-1:0]                    in_pc,
  output logic                                          in_ready,
  output logic [DECODE_WIDTH-1:0]                       out_valid,
  output logic [DECODE_WIDTH-1:0][31:0]                 out_instr,
  output logic [DECODE_WIDTH-1:0][INST_ADDR_WIDTH-1:0]  out_pc,
  input  logic [DW-1:0]                                 deq_count,
  output logic [OW-1:0]                                 occupancy,
  output logic                                          full,
  output logic                                          empty
);

  logic [31:0]                mem_instr [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] mem_pc    [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [OW-1:0] occ;

  logic [OW-1:0] free_slots;
  logic [OW-1:0] in_n;
  logic [OW-1:0] enq_n;
  logic [OW-1:0] vld_n;
  logic [OW-1:0] req_n;
  logic [OW-1:0] deq_n;
  logic          enq;

  // Status comes only from registered occupancy so in_ready never depends on deq_count.
  assign occupancy  = occ;
  assign full       = (occ == OW'(DEPTH));
  assign empty      = (occ == '0);
  assign free_slots = OW'(DEPTH) - occ;
  assign in_ready   = (free_slots >= OW'(FETCH_WIDTH));

  assign in_n  = (in_count > CW'(FETCH_WIDTH)) ? OW'(FETCH_WIDTH) : OW'(in_count);
  assign enq   = in_valid & in_ready & ~flush;
  assign enq_n = enq ? in_n : '0;

  // Decode may ask for more lanes than are valid; clamp so head never passes tail.
  assign vld_n = (occ > OW'(DECODE_WIDTH)) ? OW'(DECODE_WIDTH) : occ;
  assign req_n = OW'(deq_count);
  assign deq_n = flush ? '0 : ((req_n > vld_n) ? vld_n : req_n);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + PW'(deq_n);
      tail <= tail + PW'(enq_n);
      occ  <= occ + enq_n - deq_n;
    end
  end

  // Entry storage is deliberately left unreset; validity is tracked by occupancy alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (OW'(i) < enq_n) begin
        mem_instr[tail + PW'(i)] <= in_instr[i];
        mem_pc[tail + PW'(i)]    <= in_pc + INST_ADDR_WIDTH'(4 * i);
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_instr = '0;
    out_pc    = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      if (OW'(j) < occ) begin
        out_valid[j] = 1'b1;
        out_instr[j] = mem_instr[head + PW'(j)];
        out_pc[j]    = mem_pc[head + PW'(j)];
      end
    end
  end

endmodule

// File: tb/tb_idu_fetch_queue.sv
// Directed and randomized checks of idu_fetch_queue against a scoreboard FIFO model.
module tb_idu_fetch_queue;

  localparam int FW  = 2;
  localparam int DWD = 2;
  localparam int DP  = 8;
  localparam int AW  = 32;

  logic                     clk;
  logic                     reset;
  logic                     flush;
  logic                     in_valid;
  logic [1:0]               in_count;
  logic [FW-1:0][31:0]      in_instr;
  logic [AW-1:0]            in_pc;
  logic                     in_ready;
  logic [DWD-1:0]           out_valid;
  logic [DWD-1:0][31:0]     out_instr;
  logic [DWD-1:0][AW-1:0]   out_pc;
  logic [1:0]               deq_count;
  logic [3:0]               occupancy;
  logic                     full;
  logic                     empty;

  idu_fetch_queue #(
    .FETCH_WIDTH(FW), .DECODE_WIDTH(DWD), .DEPTH(DP), .INST_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_count(in_count), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .deq_count(deq_count), .occupancy(occupancy), .full(full), .empty(empty)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   seq    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DP));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("in_ready", 64'(in_ready), 64'((DP - q.size()) >= FW));
    for (int j = 0; j < DWD; j++) begin
      chk($sformatf("out_valid%0d", j), 64'(out_valid[j]), 64'(j < q.size()));
      chk($sformatf("out_instr%0d", j), 64'(out_instr[j]), (j < q.size()) ? 64'(q[j].instr) : 64'h0);
      chk($sformatf("out_pc%0d", j), 64'(out_pc[j]), (j < q.size()) ? 64'(q[j].pc) : 64'h0);
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, check at next negedge.
  task automatic step(input logic fl, input logic v, input int cnt,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] pc, input int dq);
    bit rdy;
    int d;
    int n;
    flush     = fl;
    in_valid  = v;
    in_count  = 2'(cnt);
    in_instr[0] = i0;
    in_instr[1] = i1;
    in_pc     = pc;
    deq_count = 2'(dq);
    rdy = ((DP - q.size()) >= FW);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      d = (q.size() < DWD) ? q.size() : DWD;
      if (dq < d) d = dq;
      repeat (d) void'(q.pop_front());
      if (v && rdy) begin
        n = (cnt < FW) ? cnt : FW;
        if (n > 0) q.push_back('{instr: i0, pc: pc});
        if (n > 1) q.push_back('{instr: i1, pc: pc + 32'd4});
      end
    end
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    deq_count = 2'd0;
    check_all();
  endtask

  task automatic bundle(input int cnt, input int dq);
    logic [31:0] base;
    base = 32'h1000 + 32'(seq) * 8;
    step(1'b0, 1'b1, cnt, 32'hA000_0000 + 32'(seq), 32'hB000_0000 + 32'(seq), base, dq);
    seq++;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_count = '0;
    in_instr = '0; in_pc = '0; deq_count = '0;

    // Reset values while reset is held
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // First bundle: visible one cycle later, PCs stepped by 4
    step(1'b0, 1'b1, 2, 32'h0050_0093, 32'h00A0_0113, 32'h100, 0);
    chk("first_occ", 64'(occupancy), 64'd2);
    chk("first_valid", 64'(out_valid), 64'b11);
    chk("first_pc0", 64'(out_pc[0]), 64'h100);
    chk("first_pc1", 64'(out_pc[1]), 64'h104);

    // Fill to DEPTH, then offer a fifth bundle that must be held off
    bundle(2, 0);
    bundle(2, 0);
    bundle(2, 0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(in_ready), 64'd0);
    bundle(2, 0);
    chk("fill_held_occ", 64'(occupancy), 64'd8);

    // Full with dequeue: enqueue rejected this cycle, accepted the next
    bundle(2, 2);
    chk("fulldeq_occ", 64'(occupancy), 64'd6);
    chk("fulldeq_ready", 64'(in_ready), 64'd1);
    bundle(2, 0);
    chk("refill_occ", 64'(occupancy), 64'd8);

    // Drain to one entry, then over-ask: clamp to one
    step(1'b0, 1'b0, 0, 0, 0, 0, 2);
    step(1'b0, 1'b0, 0, 0, 0, 0, 2);
    step(1'b0, 1'b0, 0, 0, 0, 0, 2);
    step(1'b0, 1'b0, 0, 0, 0, 0, 1);
    chk("one_left", 64'(occupancy), 64'd1);
    step(1'b0, 1'b0, 0, 0, 0, 0, 2);
    chk("clamp_empty", 64'(empty), 64'd1);
    chk("clamp_valid", 64'(out_valid), 64'd0);
    chk("clamp_instr0", 64'(out_instr[0]), 64'd0);

    // in_count of zero is a no-op; enqueue into an empty queue with dequeue asked
    bundle(0, 0);
    bundle(1, 2);

    // Flush at occupancy 5 with a bundle offered
    bundle(2, 0);
    bundle(2, 0);
    chk("pre_flush_occ", 64'(occupancy), 64'd5);
    step(1'b1, 1'b1, 2, 32'hDEAD_0001, 32'hDEAD_0002, 32'h900, 2);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    bundle(2, 0);
    chk("post_flush_instr0", 64'(out_instr[0]), 64'(32'hA000_0000 + 32'(seq - 1)));

    // Random mixed traffic across many wraps
    for (int k = 0; k < 200; k++) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), int'($urandom_range(1, 2)),
           $urandom, $urandom, $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 2)));
    end

    // Asynchronous reset mid-operation clears immediately
    bundle(2, 0);
    #2 reset = 1'b1;
    q.delete();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    bundle(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idu_fetch_queue.md
# idu_fetch_queue

Parametrised multi-entry instruction queue between fetch and the decode/rename stage, replacing the single-entry stalled-instruction register in decode. It accepts bundles of up to FETCH_WIDTH instructions per cycle, presents the DECODE_WIDTH oldest instructions to decode in program order, and retires up to DECODE_WIDTH per cycle. Stall is absorbed by occupancy, not by dropping or holding fetch data, and flush empties it in one cycle.

## Interface
Parameters:
- FETCH_WIDTH, 2, instructions per fetch bundle (≥1)
- DECODE_WIDTH, 2, instructions presented/retired per cycle (≥1, ≤DEPTH)
- DEPTH, 8, queue entries; power of 2, ≥ FETCH_WIDTH
- INST_ADDR_WIDTH, `INST_ADDR_WIDTH, PC width

Ports (clock and reset: reset reset, asynchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  async active-high reset
- flush  in  1  discard all entries and this cycle's enqueue
- in_valid  in  1  fetch bundle present
- in_count  in  $clog2(FETCH_WIDTH+1)  valid lanes in bundle, lanes 0..in_count-1
- in_instr  in  32 x FETCH_WIDTH  bundle instructions, lane 0 oldest
- in_pc  in  INST_ADDR_WIDTH  PC of lane 0; lane i PC = in_pc + 4*i
- in_ready  out  1  queue accepts a full bundle this cycle
- out_valid  out  DECODE_WIDTH  per-lane valid, thermometer from lane 0
- out_instr  out  32 x DECODE_WIDTH  oldest instructions, lane 0 oldest
- out_pc  out  INST_ADDR_WIDTH x DECODE_WIDTH  PC per output lane
- deq_count  in  $clog2(DECODE_WIDTH+1)  lanes consumed by decode this cycle
- occupancy  out  $clog2(DEPTH+1)  entries held
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0

## Operation
- Storage: DEPTH entries of {instr[31:0], pc}; head and tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH; separate occupancy counter.
- Enqueue: when in_valid & in_ready & ~flush, write lanes 0..n-1 (n = min(in_count, FETCH_WIDTH)) to tail..tail+n-1 (mod DEPTH), pc = in_pc + 4*i; tail += n. in_count 0 is a no-op.
- in_ready = (DEPTH − occupancy) ≥ FETCH_WIDTH, from registered occupancy only; no combinational path from deq_count to in_ready. Bundle arriving with in_ready=0 is not written; fetch holds it.
- Output: lane j valid iff j < occupancy; out_instr[j]/out_pc[j] = entry head+j. Invalid lanes drive 0.
- Dequeue: d = min(deq_count, valid lanes); head += d. deq_count above valid lanes is clamped, never underflows.
- Occupancy next = occupancy + n − d; simultaneous enqueue and dequeue both take effect, including when full-before-deq or empty-before-enq.
- No bypass: instruction enqueued in cycle t is visible on outputs at t+1 at earliest.
- flush: next cycle head=tail=0, occupancy=0; enqueue and dequeue in the flush cycle ignored.
- Entry contents are not reset; only pointers and occupancy.

## Timing
- Reset (async): head=tail=0, occupancy=0, empty=1, full=0, in_ready=1, out_valid=0, out_instr=0, out_pc=0.
- Reset mid-operation: all entries lost immediately; outputs at reset values while reset is high.
- Enqueue-to-output latency: 1 cycle. Dequeue effect visible next cycle.
- Wrap-around: a bundle straddling index DEPTH-1→0 is written contiguously in logical order; output lanes straddling the wrap read in logical order.
- Flush has priority over enqueue, dequeue; reset over all.
- full/empty/occupancy/in_ready are registered-state derived, glitch-free at cycle start.

## Test plan
- Reset then bundle {0x00500093, 0x00A00113}, in_count=2, in_pc=0x100, deq_count=0 -> next cycle occupancy=2, out_valid=2'b11, out_pc={0x100,0x104}, in_ready=1.
- Fill DEPTH=8 with four 2-wide bundles, no dequeue -> full=1, in_ready=0 after 4th; 5th bundle held by fetch, not written; occupancy stays 8.
- Full queue, enqueue offered with deq_count=2 -> enqueue rejected (in_ready=0), occupancy 8→6; next cycle in_ready=1 and bundle accepted, occupancy 8.
- Run head/tail past index 7 with mixed in_count 1/2 and deq_count 1/2 -> out_instr/out_pc match a reference FIFO model in order across wrap, no loss or duplication over 200 random cycles.
- occupancy=1, deq_count=2 -> d clamped to 1, occupancy=0, empty=1, out_valid=0, out_instr=0.
- occupancy=5 with in_valid=1 and flush=1 -> next cycle occupancy=0, empty=1, in_ready=1; flushed bundle never appears on outputs.
